// File: rtl/execute_md.sv
// LEGv8 execute stage: single-cycle ALU, branch-target generation and an iterative
// multiply/divide unit that stalls the pipeline for N+1 cycles per operation.
module execute_md #(
  parameter int unsigned N      = 64,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         flush_E,
  input  logic [1:0]   AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [1:0]   MdOp,
  input  logic         RegBranching,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [N-1:0] readData3_E,
  output logic [N-1:0] PCBranch_E,
  output logic [N-1:0] aluResult_E,
  output logic [N-1:0] writeData_E,
  output logic         zero_E,
  output logic         stall_E,
  output logic         divZero_E
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   hi_q, lo_q, b_q, result_q;
  logic           div_q, neg_q, divz_q;

  logic [N-1:0]   mux_out, alu_out;
  logic           is_md, accept, b_zero, a_neg, b_neg, last;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum, rem_sh;
  logic [N-1:0]   rem_try, hi_step, lo_step, final_res;
  logic           fits, stall, done_out;

  assign PCBranch_E  = RegBranching ? readData1_E : PC_E + (signImm_E << 2);
  assign writeData_E = readData2_E;

  always_comb begin
    if (AluSrc[1])      mux_out = readData3_E;
    else if (AluSrc[0]) mux_out = signImm_E;
    else                mux_out = readData2_E;
  end

  always_comb begin
    case (AluControl)
      4'b0000: alu_out = readData1_E & mux_out;
      4'b0001: alu_out = readData1_E | mux_out;
      4'b0010: alu_out = readData1_E + mux_out;
      4'b0110: alu_out = readData1_E - mux_out;
      4'b0111: alu_out = mux_out;
      4'b1100: alu_out = ~(readData1_E | mux_out);
      default: alu_out = '0;
    endcase
  end

  // With DIV_EN=0 the divide opcodes fall through to the ALU path.
  assign is_md  = valid_E && ((MdOp == 2'b01) || (DIV_EN && MdOp[1]));
  assign accept = (state_q == StIdle) && is_md && !flush_E;
  assign b_zero = (readData2_E == '0);
  assign a_neg  = (MdOp == 2'b11) && readData1_E[N-1];
  assign b_neg  = (MdOp == 2'b11) && readData2_E[N-1];
  assign a_mag  = a_neg ? -readData1_E : readData1_E;
  assign b_mag  = b_neg ? -readData2_E : readData2_E;
  assign last   = (cnt_q == CW'(N - 1));

  // Multiply: {hi,lo} is a 2N-bit accumulator shifted right, multiplier in lo.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[N-1]};
    fits    = (rem_sh >= {1'b0, b_q});
    rem_try = rem_sh[N-1:0] - b_q;
    if (div_q) begin
      hi_step = fits ? rem_try : rem_sh[N-1:0];
      lo_step = {lo_q[N-2:0], fits};
    end else begin
      hi_step = mul_sum[N:1];
      lo_step = {mul_sum[0], lo_q[N-1:1]};
    end
    final_res = (div_q && neg_q) ? -lo_step : lo_step;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          stall   = 1'b1;
          state_d = (MdOp[1] && b_zero) ? StDone : StBusy;
        end
      end
      StBusy: begin
        if (flush_E) begin
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          if (last) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q    <= '0;
        hi_q     <= '0;
        lo_q     <= a_mag;
        b_q      <= b_mag;
        div_q    <= MdOp[1];
        neg_q    <= a_neg ^ b_neg;
        divz_q   <= MdOp[1] && b_zero;
        result_q <= '0;
      end else if (state_q == StBusy && !flush_E) begin
        hi_q  <= hi_step;
        lo_q  <= lo_step;
        cnt_q <= cnt_q + 1'b1;
        if (last) result_q <= final_res;
      end
    end
  end

  assign done_out    = (state_q == StDone) && !reset;
  assign aluResult_E = done_out ? result_q : alu_out;
  assign zero_E      = (aluResult_E == '0);
  assign stall_E     = stall && !reset;
  assign divZero_E   = done_out && divz_q && !flush_E;

endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Next-generation LEGv8 pipeline execute stage, parametrised in datapath width.
- Keeps the single-cycle ALU path, the operand-B select and the relative/register branch-target generation of the current execute stage.
- Adds an iterative multiply/divide unit (MUL, UDIV, SDIV) that stalls the pipeline through a stall/flush handshake.
- Raises a one-cycle divide-by-zero flag for the exception unit.

Parameters:
- N, 64, datapath width in bits (≥8, even).
- DIV_EN, 1, 1 = UDIV/SDIV implemented; 0 = divide opcodes behave as MdOp=00.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_E  in  1  E-stage holds a real instruction.
- flush_E  in  1  squash the E-stage instruction (branch/exception).
- AluSrc  in  2  operand-B select: 00 readData2_E, 01 signImm_E, 1x readData3_E.
- AluControl  in  4  ALU function, existing encoding.
- MdOp  in  2  00 ALU, 01 MUL (low N bits), 10 UDIV, 11 SDIV.
- RegBranching  in  1  1 = branch target is readData1_E (BR); 0 = relative.
- PC_E, signImm_E, readData1_E, readData2_E, readData3_E  in  N  stage operands.
- PCBranch_E  out  N  branch target.
- aluResult_E  out  N  ALU or mul/div result.
- writeData_E  out  N  store data = readData2_E.
- zero_E  out  1  result == 0.
- stall_E  out  1  hold IF/ID/E and bubble M while high.
- divZero_E  out  1  one-cycle pulse: divide by zero.

Behaviour:
- Combinational path, independent of FSM state:
  - PCBranch_E = RegBranching ? readData1_E : PC_E + (signImm_E << 2).
  - writeData_E = readData2_E.
- Mul/div operands are always A = readData1_E, B = readData2_E; AluSrc is ignored for MdOp≠00.
- ALU result path: when MdOp=00 or valid_E=0, aluResult_E and zero_E come from the ALU on (readData1_E, mux_out) in the same cycle.
- FSM states are IDLE, BUSY, DONE.
- IDLE:
  - Accept when valid_E & MdOp≠00 & !flush_E.
  - On accept: latch operands; for SDIV latch magnitudes and sign flags; clear the counter; go to BUSY.
  - stall_E = 1 combinationally in the accept cycle.
- Divide by zero (UDIV/SDIV with B == 0) in IDLE:
  - No iteration. Go to DONE with result = 0.
  - divZero_E = 1 in the DONE cycle only.
- BUSY:
  - One iteration per cycle for exactly N cycles; counter runs 0..N-1; stall_E = 1.
  - MUL: shift-add of the multiplier LSB into a 2N-bit accumulator; keep the low N bits.
  - Divide: restoring divide, one quotient bit per cycle, MSB first.
  - At counter = N-1, go to DONE.
- DONE:
  - stall_E = 0. aluResult_E = registered result; zero_E = (result == 0).
  - The pipeline advances on this clock edge. Next state is IDLE.
  - An instruction arriving in the following cycle is a new op.
- Latency: stall_E is high for N+1 cycles (accept + N BUSY cycles); the result appears in cycle N+1. Divide by zero gives 1 stall cycle.
- SDIV sign rules:
  - Quotient truncates toward zero; negate it iff the operand signs differ.
  - MIN / -1 = MIN (wraps; no flag).
- flush_E:
  - In IDLE: no accept.
  - In BUSY: abort; stall_E = 0 in that same cycle; next state IDLE; no result.
  - In DONE: result is discarded by the pipeline; divZero_E is forced to 0.
- Operand stability: the pipeline holds E inputs stable while stall_E = 1. The unit uses only its latched copies after accept.
- Reset, in any state including mid-BUSY:
  - state = IDLE, counter = 0, latched operands/result = 0.
  - stall_E = 0, divZero_E = 0. Combinational outputs follow their inputs.
- DIV_EN = 0: MdOp 10/11 use the ALU path, never stall, and never raise divZero_E.

Test Plan:
- ALU path: valid_E=1, MdOp=00, AluSrc=01, AluControl=ADD, readData1_E=5, signImm_E=3 → aluResult_E=8 same cycle, zero_E=0, stall_E=0; PC_E=0x100, signImm_E=4, RegBranching=0 → PCBranch_E=0x110; with RegBranching=1 and readData1_E=0x2000 → PCBranch_E=0x2000.
- MUL at N=64: 7×6 → stall_E high exactly 65 cycles, then aluResult_E=42, zero_E=0. Also 0xFFFF_FFFF_FFFF_FFFF × 2 → 0xFFFF_FFFF_FFFF_FFFE.
- UDIV 100/7 → 14 after 65 stall cycles. SDIV −100/7 → −14. SDIV MIN/−1 → 0x8000_0000_0000_0000 with divZero_E=0.
- Divide by zero: UDIV 9/0 → one stall cycle, then aluResult_E=0, zero_E=1, divZero_E pulses exactly 1 cycle. The same op with flush_E=1 in the DONE cycle → divZero_E=0.
- Abort: MUL accepted, flush_E=1 at BUSY cycle 10 → stall_E=0 that cycle, FSM in IDLE next cycle. A following UDIV 20/4 → 5 with full latency.
- Reset at BUSY cycle 30 → next cycle stall_E=0, divZero_E=0, state IDLE. A back-to-back MUL then UDIV each take 65 stall cycles and both results are correct.
